regs_wb: RTL
============

// Module: regs_wb
// PURPOSE
//  Writeback end of the exe -> exe_mem result path: receives the (reg_we, reg_waddr, reg_wdata)
//  triple produced by execute, holds it in a one-entry writeback stage, commits it to the
//  integer register file and serves two decode read ports with bypass. x0 is hardwired to zero.
// PARAMETERS
//  DATA_WIDTH   32  width of a register / write data
//  RADDR_WIDTH  5   register address width
//  REG_NUM      32  number of architectural registers (2**RADDR_WIDTH)
// PORTS
//  clk_i        in   1            rising-edge clock
//  rst_n_i      in   1            asynchronous, active-low reset
//  reg_we_i     in   1            write enable from exe_mem
//  reg_waddr_i  in   RADDR_WIDTH  destination register
//  reg_wdata_i  in   DATA_WIDTH   result value
//  hold_i       in   1            stall: writeback stage keeps its content
//  flush_i      in   1            kill: writeback stage captures a bubble
//  raddr1_i     in   RADDR_WIDTH  read port 1 address (from id)
//  raddr2_i     in   RADDR_WIDTH  read port 2 address (from id)
//  rdata1_o     out  DATA_WIDTH   read port 1 data
//  rdata2_o     out  DATA_WIDTH   read port 2 data
//  wb_busy_o    out  1            writeback stage holds a valid pending write
// BEHAVIOUR
//  - Reset (rst_n_i=0, async): wb stage we=0, waddr=0, wdata=0; all REG_NUM registers = 0;
//    rdata1_o=rdata2_o=0; wb_busy_o=0. Release takes effect at the next rising edge.
//  - Stage capture, per rising edge, priority flush_i > hold_i > load:
//      flush_i=1 -> wb.we=0 (waddr/wdata don't care, driven 0);
//      hold_i=1  -> wb unchanged, no register-file commit this edge;
//      else      -> wb <= {reg_we_i & (reg_waddr_i!=0), reg_waddr_i, reg_wdata_i}.
//  - Commit: on the same edge a captured entry is replaced (not hold), if wb.we=1 then
//    regs[wb.waddr] <= wb.wdata. Latency: input at edge N -> in stage after N -> in array
//    after N+1. Commit and capture occur together on one edge; flush kills only the
//    incoming entry, never the one being committed.
//  - Writes to x0 are dropped at capture; regs[0] is never written and always reads 0.
//  - Reads are combinational. For port k:
//      raddrk_i==0                       -> 0
//      wb.we && wb.waddr==raddrk_i       -> wb.wdata (bypass)
//      else                              -> regs[raddrk_i]
//    Both ports may hit the same address or the bypass in the same cycle.
//  - wb_busy_o = wb.we (registered state, no combinational path from inputs).
//  - Back-to-back writes to same register: later value wins; bypass always shows the
//    youngest pending value. Hold with pending write: bypass keeps supplying it.
//  - Reset asserted mid-operation: pending wb entry is discarded, not committed.
//  - Upstream inputs with reg_we_i=0 still load the stage (as a bubble).
// STRUCTURE
//  - Shared defines: DATA_WIDTH, RADDR_WIDTH, REG_NUM, ZERO, ZERO_REG, WRITE_ENABLE,
//    WRITE_DISABLE live in defines.v; no local literals for these.
//  - One sub-module: regs_bypass (combinational read mux: x0 / bypass / array), instantiated
//    twice, one per read port. Stage register and array live in regs_wb.
// TESTING
//  1 Reset: drive rst_n_i=0 mid-cycle with wb.we=1 -> outputs 0 immediately, regs[5] stays 0.
//  2 Write x5=0xDEADBEEF, raddr1=5 next cycle -> rdata1=0xDEADBEEF via bypass, busy=1;
//    one cycle later (bubble in) -> same value from array, busy=0.
//  3 Write x0=0x12345678 -> busy stays 0, raddr1=raddr2=0 read 0 throughout.
//  4 Writes x7=1 then x7=2 on consecutive edges, raddr2=7 -> reads 1 then 2, array ends 2.
//  5 Write x3=0xA5 then hold_i=1 for 3 cycles -> rdata1(3)=0xA5 each cycle, regs[3] unchanged
//    until hold drops; flush_i with input x4=0x55 -> x4 never written, reads 0.
//  6 Random: 2000 cycles random we/addr/data/hold/flush vs. reference model, both ports.

Source files
------------

// File: rtl/regs_wb_pkg.sv
// rtl/regs_wb_pkg.sv - shared widths, constants and writeback entry type for regs_wb
package regs_wb_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int REG_NUM     = 2 ** RADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0]  data_t;
  typedef logic [RADDR_WIDTH-1:0] raddr_t;

  localparam data_t  ZERO          = '0;
  localparam raddr_t ZERO_REG      = '0;
  localparam logic   WRITE_ENABLE  = 1'b1;
  localparam logic   WRITE_DISABLE = 1'b0;

  // One pending register-file write held between execute and commit
  typedef struct packed {
    logic   we;
    raddr_t waddr;
    data_t  wdata;
  } wb_entry_t;

  localparam wb_entry_t WB_BUBBLE = '{we: WRITE_DISABLE, waddr: ZERO_REG, wdata: ZERO};

  // Build a stage entry; writes aimed at x0 become bubbles so x0 is never touched
  function automatic wb_entry_t make_entry(logic we, raddr_t waddr, data_t wdata);
    wb_entry_t e;
    e.we    = (we == WRITE_ENABLE) && (waddr != ZERO_REG);
    e.waddr = waddr;
    e.wdata = wdata;
    return e;
  endfunction

endpackage

// File: rtl/regs_wb_if.sv
// rtl/regs_wb_if.sv - writeback input, stall/kill and read-port bundle for regs_wb
interface regs_wb_if;
  import regs_wb_pkg::*;

  logic   reg_we_i;
  raddr_t reg_waddr_i;
  data_t  reg_wdata_i;
  logic   hold_i;
  logic   flush_i;
  raddr_t raddr1_i;
  raddr_t raddr2_i;
  data_t  rdata1_o;
  data_t  rdata2_o;
  logic   wb_busy_o;

  // Pipeline side: drives the result triple, stall/kill and read addresses
  modport master (
    output reg_we_i, reg_waddr_i, reg_wdata_i, hold_i, flush_i, raddr1_i, raddr2_i,
    input  rdata1_o, rdata2_o, wb_busy_o
  );

  // Register file side
  modport slave (
    input  reg_we_i, reg_waddr_i, reg_wdata_i, hold_i, flush_i, raddr1_i, raddr2_i,
    output rdata1_o, rdata2_o, wb_busy_o
  );

endinterface

// File: rtl/regs_wb_bypass.sv
// rtl/regs_wb_bypass.sv - combinational read mux: x0 / pending writeback / array
module regs_bypass
  import regs_wb_pkg::*;
(
  input  raddr_t    raddr,
  input  wb_entry_t wb,
  input  data_t     arr_data,
  output data_t     rdata
);

  // x0 reads zero; a pending write to the same register is younger than the array
  always_comb begin
    rdata = arr_data;
    if (raddr == ZERO_REG) begin
      rdata = ZERO;
    end else if ((wb.we == WRITE_ENABLE) && (wb.waddr == raddr)) begin
      rdata = wb.wdata;
    end
  end

endmodule

// File: rtl/regs_wb.sv
// rtl/regs_wb.sv - one-entry writeback stage, integer register file and two bypassed read ports
module regs_wb
  import regs_wb_pkg::*;
(
  input logic      clk_i,
  input logic      rst_n_i,
  regs_wb_if.slave bus
);

  wb_entry_t wb;
  data_t     regs [REG_NUM];
  logic      commit;
  data_t     arr_data1;
  data_t     arr_data2;

  // The stage entry retires whenever it is replaced: on a normal load or on a flush.
  // A flush only kills the incoming entry, so the outgoing one still commits.
  assign commit = bus.flush_i || !bus.hold_i;

  // Writeback stage capture: flush > hold > load
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb <= WB_BUBBLE;
    end else if (bus.flush_i) begin
      wb <= WB_BUBBLE;
    end else if (!bus.hold_i) begin
      wb <= make_entry(bus.reg_we_i, bus.reg_waddr_i, bus.reg_wdata_i);
    end
  end

  // Register array commit of the retiring entry; x0 is never written
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= ZERO;
      end
    end else if (commit && (wb.we == WRITE_ENABLE) && (wb.waddr != ZERO_REG)) begin
      regs[wb.waddr] <= wb.wdata;
    end
  end

  assign arr_data1 = regs[bus.raddr1_i];
  assign arr_data2 = regs[bus.raddr2_i];

  regs_bypass u_bypass1 (
    .raddr    (bus.raddr1_i),
    .wb       (wb),
    .arr_data (arr_data1),
    .rdata    (bus.rdata1_o)
  );

  regs_bypass u_bypass2 (
    .raddr    (bus.raddr2_i),
    .wb       (wb),
    .arr_data (arr_data2),
    .rdata    (bus.rdata2_o)
  );

  assign bus.wb_busy_o = wb.we;

endmodule
